// File: rtl/nan_word_deser.sv
`default_nettype none
// ============================================================================
//  Module   : nan_word_deser
//  Purpose  : Manchester word deserializer fed by a DDR input stage.
//             Each cycle two half-bit samples arrive (din_h, then din_l).
//             The block hunts for the half-bit phase (A = (h,l) or
//             B = (pl,h)), locks after LOCK_CNT consecutive valid bits and
//             then frames start(1) / WORD_W data bits MSB first / stop(0).
//  Ports    : inclock    - sole clock
//             aclr       - synchronous active-high reset
//             din_h      - rising-edge half-bit sample
//             din_l      - falling-edge half-bit sample (same cycle)
//             word       - last good data word
//             word_valid - one-cycle strobe, word updated
//             frame_err  - one-cycle strobe, frame aborted
//             code_err   - one-cycle strobe, Manchester violation in lock
//             locked     - level, alignment acquired
//  Revision : 1.0 - initial release
// ============================================================================
module nan_word_deser #(
    parameter int WORD_W     = 12,
    parameter int LOCK_CNT   = 8,
    parameter int ERR_LIMIT  = 4,
    parameter int ERR_WINDOW = 16
) (
    input  logic              inclock,
    input  logic              aclr,
    input  logic              din_h,
    input  logic              din_l,
    output logic [WORD_W-1:0] word,
    output logic              word_valid,
    output logic              frame_err,
    output logic              code_err,
    output logic              locked
);

    localparam int c_LCW = $clog2(LOCK_CNT + 1);
    localparam int c_EW  = $clog2(ERR_LIMIT + 1);
    localparam int c_WW  = $clog2(ERR_WINDOW + 1);
    localparam int c_BW  = $clog2(WORD_W + 1);

    localparam logic [c_LCW-1:0] c_LOCK_MAX = c_LCW'(LOCK_CNT);
    localparam logic [c_EW-1:0]  c_ERR_MAX  = c_EW'(ERR_LIMIT);
    localparam logic [c_WW-1:0]  c_WIN_LAST = c_WW'(ERR_WINDOW - 1);
    localparam logic [c_BW-1:0]  c_BIT_LAST = c_BW'(WORD_W - 1);

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_LOCK = 1'b1
    } align_t;

    typedef enum logic [1:0] {
        FR_IDLE = 2'd0,
        FR_DATA = 2'd1,
        FR_STOP = 2'd2
    } frame_t;

    // Registered line samples and previous-cycle falling-edge sample
    logic r_h, r_l, r_pl;

    align_t             r_align, w_align_n;
    logic               r_sel_b, w_sel_b_n;
    logic [c_LCW-1:0]   r_cnt_a, w_cnt_a_n;
    logic [c_LCW-1:0]   r_cnt_b, w_cnt_b_n;
    logic [c_EW-1:0]    r_err_cnt, w_err_n, w_err_inc;
    logic [c_WW-1:0]    r_win_cnt, w_win_n;
    logic               w_lock_drop;

    frame_t             r_frame, w_frame_n;
    logic [c_BW-1:0]    r_bit_cnt, w_bit_cnt_n;
    logic [WORD_W-1:0]  r_shift, w_shift_n;
    logic [WORD_W-1:0]  w_word_n;
    logic               w_wv_n, w_fe_n, w_ce_n;

    logic w_a_valid, w_b_valid, w_sel_valid, w_bit;

    assign w_a_valid   = r_h ^ r_l;
    assign w_b_valid   = r_pl ^ r_h;
    assign w_sel_valid = r_sel_b ? w_b_valid : w_a_valid;
    // Decoded bit is the first half of the selected pair (1 = high-then-low)
    assign w_bit       = r_sel_b ? r_pl : r_h;
    assign locked      = (r_align == ST_LOCK);

    // Alignment FSM: next state and counters
    always_comb begin
        w_align_n   = r_align;
        w_sel_b_n   = r_sel_b;
        w_cnt_a_n   = r_cnt_a;
        w_cnt_b_n   = r_cnt_b;
        w_err_n     = r_err_cnt;
        w_win_n     = r_win_cnt;
        w_lock_drop = 1'b0;
        w_err_inc   = r_err_cnt + 1'b1;
        case (r_align)
            ST_HUNT: begin
                w_cnt_a_n = w_a_valid ? r_cnt_a + 1'b1 : '0;
                w_cnt_b_n = w_b_valid ? r_cnt_b + 1'b1 : '0;
                w_err_n   = '0;
                w_win_n   = '0;
                // A is tested first so a simultaneous finish selects A
                if (w_cnt_a_n == c_LOCK_MAX) begin
                    w_align_n = ST_LOCK;
                    w_sel_b_n = 1'b0;
                    w_cnt_a_n = '0;
                    w_cnt_b_n = '0;
                end else if (w_cnt_b_n == c_LOCK_MAX) begin
                    w_align_n = ST_LOCK;
                    w_sel_b_n = 1'b1;
                    w_cnt_a_n = '0;
                    w_cnt_b_n = '0;
                end
            end
            ST_LOCK: begin
                w_cnt_a_n = '0;
                w_cnt_b_n = '0;
                if (!w_sel_valid && (w_err_inc == c_ERR_MAX)) begin
                    w_lock_drop = 1'b1;
                    w_align_n   = ST_HUNT;
                    w_err_n     = '0;
                    w_win_n     = '0;
                end else if (r_win_cnt == c_WIN_LAST) begin
                    // Window closes: the error budget starts over
                    w_err_n = '0;
                    w_win_n = '0;
                end else begin
                    w_win_n = r_win_cnt + 1'b1;
                    w_err_n = w_sel_valid ? r_err_cnt : w_err_inc;
                end
            end
            default: w_align_n = ST_HUNT;
        endcase
    end

    // Frame FSM: runs only on decoded bits while locked
    always_comb begin
        w_frame_n   = r_frame;
        w_bit_cnt_n = r_bit_cnt;
        w_shift_n   = r_shift;
        w_word_n    = word;
        w_wv_n      = 1'b0;
        w_fe_n      = 1'b0;
        w_ce_n      = 1'b0;
        if (r_align == ST_LOCK) begin
            w_ce_n = !w_sel_valid;
            case (r_frame)
                FR_IDLE: begin
                    if (w_sel_valid && w_bit) begin
                        w_frame_n   = FR_DATA;
                        w_bit_cnt_n = '0;
                    end
                end
                FR_DATA: begin
                    if (!w_sel_valid) begin
                        w_fe_n    = 1'b1;
                        w_frame_n = FR_IDLE;
                    end else begin
                        w_shift_n = {r_shift[WORD_W-2:0], w_bit};
                        if (r_bit_cnt == c_BIT_LAST) begin
                            w_frame_n = FR_STOP;
                        end else begin
                            w_bit_cnt_n = r_bit_cnt + 1'b1;
                        end
                    end
                end
                FR_STOP: begin
                    w_frame_n = FR_IDLE;
                    if (w_sel_valid && !w_bit) begin
                        w_word_n = r_shift;
                        w_wv_n   = 1'b1;
                    end else begin
                        w_fe_n = 1'b1;
                    end
                end
                default: w_frame_n = FR_IDLE;
            endcase
            // Losing lock always wins over a completing frame
            if (w_lock_drop) begin
                w_frame_n = FR_IDLE;
                if (r_frame != FR_IDLE) begin
                    w_wv_n   = 1'b0;
                    w_word_n = word;
                    w_fe_n   = 1'b1;
                end
            end
        end else begin
            w_frame_n = FR_IDLE;
        end
    end

    always_ff @(posedge inclock) begin
        if (aclr) begin
            r_h        <= 1'b0;
            r_l        <= 1'b0;
            r_pl       <= 1'b0;
            r_align    <= ST_HUNT;
            r_sel_b    <= 1'b0;
            r_cnt_a    <= '0;
            r_cnt_b    <= '0;
            r_err_cnt  <= '0;
            r_win_cnt  <= '0;
            r_frame    <= FR_IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            code_err   <= 1'b0;
        end else begin
            r_h        <= din_h;
            r_l        <= din_l;
            r_pl       <= r_l;
            r_align    <= w_align_n;
            r_sel_b    <= w_sel_b_n;
            r_cnt_a    <= w_cnt_a_n;
            r_cnt_b    <= w_cnt_b_n;
            r_err_cnt  <= w_err_n;
            r_win_cnt  <= w_win_n;
            r_frame    <= w_frame_n;
            r_bit_cnt  <= w_bit_cnt_n;
            r_shift    <= w_shift_n;
            word       <= w_word_n;
            word_valid <= w_wv_n;
            frame_err  <= w_fe_n;
            code_err   <= w_ce_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nan_word_deser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nan_word_deser
//  Purpose  : Scoreboard bench for nan_word_deser. Stimulus pushes expected
//             strobe events and level expectations into queues; a monitor
//             on the falling clock edge pops and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nan_word_deser;

    localparam int W = 12;

    logic         inclock = 1'b0;
    logic         aclr    = 1'b0;
    logic         din_h   = 1'b0;
    logic         din_l   = 1'b0;
    logic [W-1:0] word;
    logic         word_valid, frame_err, code_err, locked;

    nan_word_deser #(
        .WORD_W    (W),
        .LOCK_CNT  (8),
        .ERR_LIMIT (4),
        .ERR_WINDOW(16)
    ) dut (
        .inclock   (inclock),
        .aclr      (aclr),
        .din_h     (din_h),
        .din_l     (din_l),
        .word      (word),
        .word_valid(word_valid),
        .frame_err (frame_err),
        .code_err  (code_err),
        .locked    (locked)
    );

    always #5 inclock = ~inclock;

    int cyc = 0;
    always @(posedge inclock) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        bit           wv;
        bit           fe;
        bit           ce;
        logic [W-1:0] word;
    } ev_t;

    typedef struct {
        int           cyc;
        bit           lk;
        bit           chk_word;
        logic [W-1:0] word;
    } lv_t;

    ev_t ev_q[$];
    lv_t lv_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  mode_b   = 1'b0;
    logic pend    = 1'b1;

    task automatic push_ev(input int c, input bit wv, input bit fe, input bit ce,
                           input logic [W-1:0] w);
        ev_t e;
        e.cyc = c; e.wv = wv; e.fe = fe; e.ce = ce; e.word = w;
        ev_q.push_back(e);
    endtask

    task automatic push_lv(input int c, input bit lk, input bit chk, input logic [W-1:0] w);
        lv_t l;
        l.cyc = c; l.lk = lk; l.chk_word = chk; l.word = w;
        lv_q.push_back(l);
    endtask

    // One inclock cycle of line data
    task automatic drive(input logic h, input logic l);
        @(posedge inclock);
        #1;
        din_h = h;
        din_l = l;
    endtask

    // B phase: a bit's first half rides on din_l, its second half on the next din_h
    task automatic send_bit(input logic b);
        if (mode_b) begin
            drive(pend, b);
            pend = ~b;
        end else begin
            drive(b, ~b);
        end
    endtask

    task automatic do_reset();
        @(posedge inclock);
        #1;
        aclr  = 1'b1;
        din_h = 1'b0;
        din_l = 1'b0;
        push_lv(cyc + 1, 1'b0, 1'b1, '0);
        @(posedge inclock);
        #1;
        aclr = 1'b0;
    endtask

    // Eight valid bits from HUNT; locked rises two cycles after the eighth.
    // With a marker, the first of the eight is a 1 (gives B a lead over A).
    task automatic lock_seq(input bit marker);
        if (marker) send_bit(1'b1);
        repeat (marker ? 7 : 8) send_bit(1'b0);
        push_lv(cyc + 1, 1'b0, 1'b0, '0);
        push_lv(cyc + 2, 1'b1, 1'b0, '0);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic stop,
                              input logic [W-1:0] word_exp);
        int c;
        send_bit(1'b1);
        for (int i = W - 1; i >= 0; i--) send_bit(d[i]);
        send_bit(stop);
        c = mode_b ? cyc + 3 : cyc + 2;
        push_ev(c, !stop, stop, 1'b0, word_exp);
    endtask

    always @(negedge inclock) begin : mon
        ev_t e;
        lv_t l;
        while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
            e = ev_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL ev_missing cyc=%0d actual=none required wv=%0b fe=%0b ce=%0b at cyc=%0d",
                     cyc, e.wv, e.fe, e.ce, e.cyc);
        end
        if (word_valid === 1'b1 || frame_err === 1'b1 || code_err === 1'b1) begin
            if (ev_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL ev_unexpected cyc=%0d actual wv=%0b fe=%0b ce=%0b required none",
                         cyc, word_valid, frame_err, code_err);
            end else begin
                e = ev_q.pop_front();
                n_checks++;
                if (e.cyc != cyc) begin
                    n_fail++;
                    $display("FAIL ev_latency actual cyc=%0d required cyc=%0d", cyc, e.cyc);
                end
                n_checks++;
                if ({word_valid, frame_err, code_err} !== {e.wv, e.fe, e.ce} || word !== e.word) begin
                    n_fail++;
                    $display("FAIL ev_content cyc=%0d actual wv=%0b fe=%0b ce=%0b word=%h required wv=%0b fe=%0b ce=%0b word=%h",
                             cyc, word_valid, frame_err, code_err, word, e.wv, e.fe, e.ce, e.word);
                end
            end
        end
        while (lv_q.size() > 0 && lv_q[0].cyc <= cyc) begin
            l = lv_q.pop_front();
            if (l.cyc == cyc) begin
                n_checks++;
                if (locked !== l.lk) begin
                    n_fail++;
                    $display("FAIL locked cyc=%0d actual=%b required=%b", cyc, locked, l.lk);
                end
                if (l.chk_word) begin
                    n_checks++;
                    if (word !== l.word) begin
                        n_fail++;
                        $display("FAIL word_level cyc=%0d actual=%h required=%h", cyc, word, l.word);
                    end
                end
            end
        end
    end

    initial begin
        // A alignment: idle lock, then a good frame
        do_reset();
        mode_b = 1'b0;
        lock_seq(1'b0);
        send_frame(12'hA5C, 1'b0, 12'hA5C);
        repeat (2) send_bit(1'b0);

        // B alignment: idle zeros alone are valid in both phases, so a
        // marker bit breaks the symmetry in favour of B
        do_reset();
        mode_b = 1'b1;
        pend   = 1'b1;
        lock_seq(1'b1);
        send_frame(12'hA5C, 1'b0, 12'hA5C);
        repeat (2) send_bit(1'b0);

        // Bad stop bit: frame_err, word holds
        send_frame(12'h123, 1'b1, 12'hA5C);
        repeat (2) send_bit(1'b0);

        // Four violations inside one window drop lock, then relock
        do_reset();
        mode_b = 1'b0;
        lock_seq(1'b0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0);
            push_ev(cyc + 2, 1'b0, 1'b0, 1'b1, 12'h000);
            if (k < 3) begin
                send_bit(1'b0);
            end else begin
                push_lv(cyc + 1, 1'b1, 1'b0, '0);
                push_lv(cyc + 2, 1'b0, 1'b0, '0);
            end
        end
        lock_seq(1'b0);
        send_frame(12'h3C3, 1'b0, 12'h3C3);
        repeat (2) send_bit(1'b0);

        // Reset in the middle of DATA, then relock and decode
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        do_reset();
        lock_seq(1'b0);
        send_frame(12'h5A3, 1'b0, 12'h5A3);

        // Back-to-back frames: strobes 14 cycles apart
        send_frame(12'hFFF, 1'b0, 12'hFFF);
        send_frame(12'h000, 1'b0, 12'h000);
        repeat (4) send_bit(1'b0);
        repeat (3) @(posedge inclock);
        #1;

        n_checks++;
        if (ev_q.size() != 0) begin
            n_fail++;
            $display("FAIL ev_queue_drain actual=%0d required=0", ev_q.size());
        end
        n_checks++;
        if (lv_q.size() != 0) begin
            n_fail++;
            $display("FAIL lv_queue_drain actual=%0d required=0", lv_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
